// File: rtl/kernel_sum_stream.sv
// Streaming kernel-coefficient summer feeding the normalisation divider.
// Ports: clk, rst (async high), in_valid/in_ready/in_data (LANES words per
// beat), kernel_abort (drop partial kernel), sum_valid/sum_ready/sum/sum_ovf.
module kernel_sum_stream #(
    parameter int TAPS  = 49,
    parameter int LANES = 7,
    parameter int WIDTH = 16,
    parameter int OUT_W = 24,
    parameter bit SAT   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   kernel_abort,
    output logic                   sum_valid,
    input  logic                   sum_ready,
    output logic [OUT_W-1:0]       sum,
    output logic                   sum_ovf
);
    localparam int BEATS = (TAPS + LANES - 1) / LANES;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Number of live lanes on the final beat of a kernel.
    localparam int VLAST = TAPS - (BEATS - 1) * LANES;
    localparam int S1W   = WIDTH + $clog2(LANES);
    // Adder width wide enough for both operands plus a carry.
    localparam int AW    = ((OUT_W + 1) > (S1W + 1)) ? OUT_W + 1 : S1W + 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    logic             adv;
    logic             accept;
    logic             last_beat;
    logic [BCW-1:0]   beat;
    logic [S1W-1:0]   lane_sum;
    logic [S1W-1:0]   s1_sum;
    logic             s1_valid;
    logic             s1_last;
    logic [OUT_W-1:0] acc;
    logic             ovf_acc;
    logic [AW-1:0]    add_full;
    logic             add_ovf;
    logic [OUT_W-1:0] add_res;

    assign adv       = !sum_valid || sum_ready;
    assign in_ready  = !rst && adv;
    assign accept    = in_valid && in_ready && !kernel_abort;
    assign last_beat = (beat == LAST_BEAT);

    // Lanes past the end of the kernel on the final beat are ignored.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!last_beat || i < VLAST)
                lane_sum = lane_sum + S1W'(in_data[i*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        add_full = AW'(acc) + AW'(s1_sum);
        add_ovf  = |add_full[AW-1:OUT_W];
        add_res  = add_full[OUT_W-1:0];
        if (SAT && add_ovf)
            add_res = '1;
    end

    // Stage 1: beat counter and per-beat lane sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat     <= '0;
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_last  <= 1'b0;
        end else if (kernel_abort) begin
            beat     <= '0;
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum  <= lane_sum;
                s1_last <= last_beat;
                beat    <= last_beat ? '0 : beat + BCW'(1);
            end
        end
    end

    // Stage 2: accumulate and publish the kernel sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            ovf_acc   <= 1'b0;
            sum_valid <= 1'b0;
            sum       <= '0;
            sum_ovf   <= 1'b0;
        end else begin
            // A new result written below overrides this clear.
            if (sum_valid && sum_ready)
                sum_valid <= 1'b0;
            if (kernel_abort) begin
                acc     <= '0;
                ovf_acc <= 1'b0;
            end else if (adv && s1_valid) begin
                if (s1_last) begin
                    sum       <= add_res;
                    sum_ovf   <= ovf_acc | add_ovf;
                    sum_valid <= 1'b1;
                    acc       <= '0;
                    ovf_acc   <= 1'b0;
                end else begin
                    acc     <= add_res;
                    ovf_acc <= ovf_acc | add_ovf;
                end
            end
        end
    end
endmodule

// File: doc/kernel_sum_stream.md
# kernel_sum_stream

Parametrised, streaming successor to the bilateral-filter kernel summer. It accumulates a TAPS-coefficient kernel delivered as LANES unsigned fixed-point words per beat and produces one sum per kernel. The sum is used to normalise the filter output. It sits between the kernel-weight generator and the normalisation divider, with valid/ready handshakes on both sides, selectable saturate/wrap overflow handling, and abort of a partial kernel.

## Interface
- TAPS, 49: coefficients per kernel (≥1).
- LANES, 7: coefficients per input beat (≥1). BEATS = ceil(TAPS/LANES).
- WIDTH, 16: unsigned coefficient width.
- OUT_W, 24: sum width (≥ WIDTH).
- SAT, 1: 1 = saturate on overflow, 0 = wrap modulo 2^OUT_W.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted on an edge where in_valid && in_ready.
- in_data  in  LANES*WIDTH  lane i = in_data[i*WIDTH +: WIDTH]; coefficient index = beat*LANES + i.
- kernel_abort  in  1  single-cycle pulse; discards the partial kernel.
- sum_valid  out  1  result valid; held until consumed.
- sum_ready  in  1  downstream accepts result.
- sum  out  OUT_W  kernel sum.
- sum_ovf  out  1  overflow occurred in this kernel; qualified by sum_valid.

## Operation
- Beat counter 0..BEATS-1 counts accepted beats. It wraps to 0 after the last beat (beat BEATS-1 = last).
- Lane masking: on the last beat, lanes with index ≥ TAPS − (BEATS−1)*LANES are forced to zero.
- Stage 1 (on accept): s1_sum = sum of the masked lanes, width WIDTH+clog2(LANES), exact. Also captures s1_valid and s1_last.
- Stage 2 (when s1_valid and the pipeline advances):
  - Not last: acc ← acc + s1_sum.
  - Last: sum ← acc + s1_sum; sum_valid ← 1; acc ← 0; ovf_acc ← 0.
- Overflow is evaluated on every stage-2 addition at OUT_W+1 bits.
  - SAT=1: clamp to 2^OUT_W−1. A clamped acc stays clamped.
  - SAT=0: keep the low OUT_W bits.
  - In either mode, any overflow in the kernel sets sticky ovf_acc. sum_ovf = ovf_acc OR overflow on the final add.
- Pipeline advance: adv = !sum_valid || sum_ready. All stages hold when adv=0.
- in_ready = !rst && adv. This is combinational from sum_ready, by design.
- Output handshake: if sum_valid && sum_ready and no new last result is being written, sum_valid ← 0. A simultaneous consume and new result keeps sum_valid=1 with the new value.
- kernel_abort has priority over everything except rst.
  - Clears the beat counter, acc, ovf_acc and s1_valid.
  - A beat presented in the same cycle is dropped (not counted).
  - A completed sum already in the output register is unaffected.
- Reset (async, any time): beat counter, acc, ovf_acc, s1_valid = 0. Outputs: sum_valid=0, sum=0, sum_ovf=0, in_ready=0 while rst is high. The partial kernel is lost.

## Timing
- Latency: last beat accepted on edge E → sum_valid=1 after edge E+1.
- Throughput: one beat per cycle when sum_ready=1. Back-to-back kernels need no bubble; the accumulator clears on the same edge the result is written.
- Backpressure: with sum_valid=1 and sum_ready=0, in_ready=0 and stage 1 holds. No beat or result is lost or reordered.
- in_data is only sampled on an accepting edge.

## Test plan
- Defaults, all 49 coefficients = 1, sum_ready=1, 7 consecutive beats → sum=49, sum_ovf=0, sum_valid exactly one cycle after the 7th accept, high for one cycle.
- TAPS=10, LANES=4: 3 beats of 0x0100, with final-beat lanes 2–3 driven 0xFFFF → sum=0x000A00 (the masked lanes are ignored).
- TAPS=49, all 0xFFFF, OUT_W=20:
  - SAT=1 → sum=0xFFFFF, sum_ovf=1.
  - SAT=0 → sum=0x0FFCF (3211215 mod 2^20), sum_ovf=1.
  - A following kernel of all 1s → 49, sum_ovf=0.
- Two kernels back-to-back (all 1s, then all 2s), with sum_ready=0 for 5 cycles when the first result appears:
  - in_ready low throughout the stall.
  - Results 49 then 98, in order, each held stable until accepted.
- 3 beats of 5s, then kernel_abort asserted together with in_valid, then a full kernel of 2s → single result 98; the aborting beat is not counted.
- rst asserted after 4 beats for 1 cycle → outputs zero immediately, in_ready=0 during reset. A following full kernel of 3s → 147.
